// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial wide adder sequencer around a registered 8-bit adder stage.
// Issues operand bytes LSB first, chains the registered carry, reassembles the sum.
module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_cin,
  output logic [7:0]          add_din1,
  output logic [7:0]          add_din2,
  output logic                add_cin,
  input  logic [7:0]          add_dout,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cin;
  logic            r_cout;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_prev;
  logic            w_accept;

  assign w_prev   = r_idx - IW'(1);
  assign w_accept = in_valid & in_ready;
  assign out_sum  = r_sum;
  assign out_cout = r_cout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_din1  = 8'h00;
    add_din2  = 8'h00;
    add_cin   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = ~rst;
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        if (!rst) begin
          add_din1 = r_a[{r_idx, 3'b000} +: 8];
          add_din2 = r_b[{r_idx, 3'b000} +: 8];
          // byte 0 never looks at the adder's stale carry
          add_cin  = (r_idx == '0) ? r_cin : add_cout;
        end
        if (r_idx == LAST) w_next = DRAIN;
      end
      DRAIN: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_idx  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_cin <= in_cin;
          end
        end
        ISSUE: begin
          r_idx <= (r_idx == LAST) ? '0 : r_idx + IW'(1);
          if (r_idx != '0) r_sum[{w_prev, 3'b000} +: 8] <= add_dout;
        end
        DRAIN: begin
          r_sum[W-8 +: 8] <= add_dout;
          r_cout          <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Bench for byte_serial_add_ctrl with an inline registered 8-bit adder.
// Directed cases plus random operand pairs against wide-integer arithmetic.
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [7:0]  add_din1;
  logic [7:0]  add_din2;
  logic        add_cin;
  logic [7:0]  add_dout;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;

  int n_vec;
  int n_err;

  logic [31:0] next_a;
  logic [31:0] next_b;
  logic        next_c;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_din1(add_din1), .add_din2(add_din2), .add_cin(add_cin),
    .add_dout(add_dout), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  // registered adder stage, deliberately without reset
  always_ff @(posedge clk)
    {add_cout, add_dout} <= {1'b0, add_din1} + {1'b0, add_din2}
                            + {8'h00, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input  logic [31:0] a,
                       input  logic [31:0] b,
                       input  logic        c,
                       input  int          stall,
                       input  bit          hold,
                       input  int          rst_at,
                       output logic [32:0] got,
                       output logic [3:0]  seq);
    logic [63:0] exp;
    logic [63:0] m;
    logic [63:0] ec;
    int cnt;
    exp = 64'(a) + 64'(b) + 64'(c);
    got = '0;
    seq = '0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    out_ready = (stall == 0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'($urandom);
    for (cnt = 0; cnt < 20; cnt++) begin
      @(negedge clk);
      if (cnt == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_din", {add_din1, add_din2, add_cin}, 64'd0);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", {out_cout, out_sum}, 64'd0);
        rst = 1'b0;
        return;
      end
      if (cnt < NB) begin
        m  = (64'd1 << (8 * cnt)) - 64'd1;
        ec = (cnt == 0) ? 64'(c)
             : (((a & m) + (b & m) + 64'(c)) >> (8 * cnt)) & 64'd1;
        chk("din1", 64'(add_din1), (64'(a) >> (8 * cnt)) & 64'hFF);
        chk("din2", 64'(add_din2), (64'(b) >> (8 * cnt)) & 64'hFF);
        chk("cin", 64'(add_cin), ec);
        seq[cnt] = add_cin;
      end else if (!out_valid) begin
        chk("drain_din", {add_din1, add_din2, add_cin}, 64'd0);
      end
      if (out_valid) break;
    end
    chk("latency", 64'(cnt), 64'd5);
    chk("done_ready", 64'(in_ready), 64'd0);
    got = {out_cout, out_sum};
    chk("sum", 64'(got), exp & 64'h1_FFFF_FFFF);
    if (hold) begin
      in_valid = 1'b1;
      in_a     = next_a;
      in_b     = next_b;
      in_cin   = next_c;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_sum", {out_cout, out_sum}, 64'(got));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [32:0] got;
    logic [3:0]  seq;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    int          st;
    bit          hv;
    bit          pend;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    next_a    = '0;
    next_b    = '0;
    next_c    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(in_ready), 64'd0);
    chk("reset_din", {add_din1, add_din2, add_cin}, 64'd0);
    rst = 1'b0;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", {out_cout, out_sum}, 64'd0);

    do_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, -1, got, seq);
    chk("t1_sum", 64'(got), 64'h0_0000_0100);
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 1'b0, -1, got, seq);
    chk("t2_sum", 64'(got), 64'h1_0000_0000);
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 1'b0, -1, got, seq);
    chk("t3_sum", 64'(got), 64'h0_ACF1_3568);
    chk("t3_cinseq", 64'(seq), 64'h6);

    next_a = 32'h0F0F0F0F;
    next_b = 32'h01010101;
    next_c = 1'b1;
    do_op(32'hDEADBEEF, 32'h11111111, 1'b0, 3, 1'b1, -1, got, seq);
    chk("t4_first", 64'(got), 64'h0_EFBE_D000);
    do_op(next_a, next_b, next_c, 0, 1'b0, -1, got, seq);
    chk("t4_second", 64'(got), 64'h0_1010_1011);

    do_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b1, 0, 1'b0, 2, got, seq);
    do_op(32'h00000001, 32'h00000001, 1'b0, 0, 1'b0, -1, got, seq);
    chk("t5_sum", 64'(got), 64'h0_0000_0002);

    pend = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pend) begin
        ra = next_a;
        rb = next_b;
        rc = next_c;
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        rb = ($urandom_range(0, 7) == 0) ? 32'h00000000 : $urandom;
        rc = 1'($urandom);
      end
      st     = $urandom_range(0, 3);
      hv     = (st > 0) && ($urandom_range(0, 1) == 1);
      next_a = $urandom;
      next_b = $urandom;
      next_c = 1'($urandom);
      do_op(ra, rb, rc, st, hv, -1, got, seq);
      pend = hv;
    end
    if (pend) do_op(next_a, next_b, next_c, 0, 1'b0, -1, got, seq);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
